// File: rtl/stack_cmd_issuer.sv
`default_nettype none
// ============================================================================
//  Module   : stack_cmd_issuer
//  Purpose  : Upstream stage of the stack unit. Host commands (3-bit op plus
//             32-bit operand) are buffered in a DEPTH-entry FIFO and handed to
//             the stack unit one at a time over a four-phase rdy/ack
//             handshake. The opcode is carried through without interpretation.
//
//  Ports    : clock        in   system clock, rising edge
//             reset_n      in   asynchronous active-low reset
//             host_valid   in   host offers a command this cycle
//             host_op      in   [2:0]  command opcode
//             host_data    in   [31:0] command operand
//             host_ready   out  FIFO can accept (count != DEPTH)
//             datain       out  [31:0] registered operand to the stack unit
//             op           out  [2:0]  registered opcode to the stack unit
//             rdy_out      out  request to the stack unit
//             ack_in       in   acknowledge from the stack unit
//             count        out  [AW:0] entries queued, excluding the one presented
//             busy         out  FSM not idle or FIFO not empty
//             timeout_err  out  sticky abort flag
//             err_clr      in   synchronous clear of timeout_err
//
//  Options  : STACK_CMD_TIMEOUT_EN - when defined, a request left
//             unacknowledged for TIMEOUT cycles is aborted and timeout_err
//             is set. When undefined, the request waits indefinitely and
//             timeout_err is tied low.
//
//  Revision : 1.0 - initial release
// ============================================================================
module stack_cmd_issuer #(
    parameter int DEPTH   = 8,
    parameter int AW      = 3,
    parameter int TIMEOUT = 64
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          host_valid,
    input  logic [2:0]    host_op,
    input  logic [31:0]   host_data,
    output logic          host_ready,
    output logic [31:0]   datain,
    output logic [2:0]    op,
    output logic          rdy_out,
    input  logic          ack_in,
    output logic [AW:0]   count,
    output logic          busy,
    output logic          timeout_err,
    input  logic          err_clr
);

    localparam logic [AW:0] C_DEPTH = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESENT = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------------
    logic [2:0]    op_mem   [DEPTH];
    logic [31:0]   data_mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;

    state_t        state_q;
    logic          rdy_q;
    logic [31:0]   datain_q;
    logic [2:0]    op_q;

    logic          w_push;
    logic          w_pop;
    logic          w_tmo_fire;

    // A full FIFO refuses the push even if the FSM pops in the same cycle;
    // this keeps host_ready a pure function of registered state.
    assign host_ready = (count_q != C_DEPTH);
    assign w_push     = host_valid & host_ready;
    assign w_pop      = (state_q == S_IDLE) && (count_q != '0);

    // ------------------------------------------------------------------------
    // FIFO pointer / occupancy next-state. DEPTH is a power of two, so the
    // AW-bit pointers wrap naturally.
    // ------------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Data storage needs no reset: an entry is only read after being written.
    always_ff @(posedge clock) begin
        if (w_push) begin
            op_mem[wr_ptr_q]   <= host_op;
            data_mem[wr_ptr_q] <= host_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // ------------------------------------------------------------------------
    // Optional acknowledge timeout
    // ------------------------------------------------------------------------
`ifdef STACK_CMD_TIMEOUT_EN
    localparam int              TW         = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]   C_TMO_LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] tmo_q;
    logic          err_q;

    // The counter holds the number of completed PRESENT cycles, so the
    // abort happens on the TIMEOUT-th edge spent in PRESENT. An ack on that
    // same edge takes priority and is treated as a normal acknowledge.
    assign w_tmo_fire = (state_q == S_PRESENT) && !ack_in && (tmo_q == C_TMO_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tmo_q <= '0;
        end else if (state_q != S_PRESENT) begin
            tmo_q <= '0;
        end else if (!ack_in && !w_tmo_fire) begin
            tmo_q <= tmo_q + 1'b1;
        end
    end

    // Set has priority over clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else if (w_tmo_fire) begin
            err_q <= 1'b1;
        end else if (err_clr) begin
            err_q <= 1'b0;
        end
    end

    assign timeout_err = err_q;
`else
    logic w_unused;

    assign w_tmo_fire  = 1'b0;
    assign timeout_err = 1'b0;
    assign w_unused    = err_clr | (TIMEOUT < 1);
`endif

    // ------------------------------------------------------------------------
    // Handshake FSM with registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            rdy_q    <= 1'b0;
            datain_q <= '0;
            op_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_pop) begin
                        datain_q <= data_mem[rd_ptr_q];
                        op_q     <= op_mem[rd_ptr_q];
                        rdy_q    <= 1'b1;
                        state_q  <= S_PRESENT;
                    end
                end
                S_PRESENT: begin
                    // A timed-out command is simply dropped; RELEASE still
                    // waits for ack to be low before the next one goes out.
                    if (ack_in || w_tmo_fire) begin
                        rdy_q   <= 1'b0;
                        state_q <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (!ack_in) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    rdy_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign rdy_out = rdy_q;
    assign datain  = datain_q;
    assign op      = op_q;
    assign count   = count_q;
    assign busy    = (state_q != S_IDLE) || (count_q != '0);

endmodule
`default_nettype wire
